// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run controller for the MIPS cores: CPU reset sequencing, cycle/store counting, halt/timeout detection
//
// Purpose:
//   Holds the CPU in reset until a start request arrives. It then keeps cpu_rst_o
//   high for RST_CYCLES cycles and releases the CPU into RUN. While in RUN it counts
//   cycles and data-memory stores. A run ends in DONE when the halt instruction is
//   fetched, and in TIMEOUT when MAX_CYCLES RUN cycles have elapsed without a halt.
//   In DONE and TIMEOUT the CPU is frozen in reset and the counters hold until the
//   next start.
//
// Optional feature (macro STALL_DET_EN):
//   When defined, a PC that stays unchanged for STALL_LIMIT consecutive RUN cycles
//   (a "j ." self-loop) also ends the run in DONE. When undefined, prev_adr and
//   stable_cnt are not built, and only HALT_INST or the timeout end a run.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   start_i        single-cycle run request (accepted in IDLE, DONE, TIMEOUT)
//   inst_adr_i     CPU program counter
//   inst_i         instruction currently fetched
//   mem_write_i    CPU data-memory write strobe
//   cpu_rst_o      reset to the CPU, active-high
//   running_o      high while in RUN
//   done_o         run ended by halt (held until the next start)
//   timeout_o      run ended by MAX_CYCLES (held until the next start)
//   cycle_count_o  RUN cycles elapsed
//   store_count_o  mem_write cycles seen in RUN, saturating

module cpu_run_ctrl #(
    parameter int                ADDR_W      = 32,
    parameter int                INST_W      = 32,
    parameter int                CNT_W       = 16,
    parameter int                RST_CYCLES  = 2,
    parameter int                MAX_CYCLES  = 312,
    parameter logic [INST_W-1:0] HALT_INST   = INST_W'(32'h0000000C),
    parameter int                STALL_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] inst_adr_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              mem_write_i,
    output logic              cpu_rst_o,
    output logic              running_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  cycle_count_o,
    output logic [CNT_W-1:0]  store_count_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    // The reset counter must be able to hold RST_CYCLES. RUN is entered on the
    // edge where the counter shows RST_CYCLES-1, because the start edge itself
    // already opened the first RESET cycle.
    localparam int                RCNT_W   = $clog2(RST_CYCLES + 1);
    localparam logic [RCNT_W-1:0] RST_LAST = RCNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_CYCLES);

    state_t              state_q, state_d;
    logic [RCNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [CNT_W-1:0]    store_q, store_d;
    logic [CNT_W-1:0]    cycle_inc;
    logic                start_ok;
    logic                stall_hit;
    logic                halt_hit;

    // start is honoured only in the states that are waiting for a run.
    assign start_ok  = start_i && (state_q == S_IDLE || state_q == S_DONE ||
                                   state_q == S_TIMEOUT);
    assign cycle_inc = cycle_q + CNT_W'(1);

`ifdef STALL_DET_EN
    // Self-loop detector. stable_cnt counts the RUN cycles whose PC repeats the
    // PC of the previous RUN cycle. In the first RUN cycle (cycle_q still 0),
    // prev_adr holds a value from an earlier run, so no comparison is made.
    localparam int                SCNT_W    = $clog2(STALL_LIMIT + 1);
    localparam logic [SCNT_W-1:0] STALL_MAX = SCNT_W'(STALL_LIMIT);

    logic [ADDR_W-1:0] prev_adr_q, prev_adr_d;
    logic [SCNT_W-1:0] stable_cnt_q, stable_cnt_d;

    always_comb begin
        prev_adr_d   = prev_adr_q;
        stable_cnt_d = stable_cnt_q;
        if (state_q == S_RUN) begin
            prev_adr_d = inst_adr_i;
            if (cycle_q != '0 && inst_adr_i == prev_adr_q) begin
                stable_cnt_d = stable_cnt_q + SCNT_W'(1);
            end else begin
                stable_cnt_d = '0;
            end
        end else if (state_q == S_RESET) begin
            stable_cnt_d = '0;
        end
    end

    // The stall decision uses the updated count, so the cycle that completes the
    // repeat sequence is the one that ends the run (and is itself counted).
    assign stall_hit = (state_q == S_RUN) && (stable_cnt_d == STALL_MAX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_adr_q   <= '0;
            stable_cnt_q <= '0;
        end else begin
            prev_adr_q   <= prev_adr_d;
            stable_cnt_q <= stable_cnt_d;
        end
    end
`else
    logic unused_inst_adr;

    assign stall_hit       = 1'b0;
    assign unused_inst_adr = ^inst_adr_i;
`endif

    assign halt_hit = (inst_i == HALT_INST) || stall_hit;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A halt takes priority over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start_i) begin
                    state_d = S_RESET;
                end
            end
            S_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (halt_hit) begin
                    state_d = S_DONE;
                end else if (cycle_inc == MAX_CNT) begin
                    state_d = S_TIMEOUT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the state flops only. No input reaches these outputs
    // combinationally.
    always_comb begin
        cpu_rst_o = 1'b1;
        running_o = 1'b0;
        done_o    = 1'b0;
        timeout_o = 1'b0;
        case (state_q)
            S_RUN: begin
                cpu_rst_o = 1'b0;
                running_o = 1'b1;
            end
            S_DONE:    done_o    = 1'b1;
            S_TIMEOUT: timeout_o = 1'b1;
            default: ;
        endcase
    end

    // Counter next-state. The counters are cleared on an accepted start and hold
    // in every state other than RESET and RUN.
    always_comb begin
        rst_cnt_d = rst_cnt_q;
        cycle_d   = cycle_q;
        store_d   = store_q;
        if (start_ok) begin
            rst_cnt_d = '0;
            cycle_d   = '0;
            store_d   = '0;
        end else if (state_q == S_RESET) begin
            rst_cnt_d = rst_cnt_q + RCNT_W'(1);
        end else if (state_q == S_RUN) begin
            cycle_d = cycle_inc;
            if (mem_write_i && store_q != '1) begin
                store_d = store_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rst_cnt_q <= '0;
            cycle_q   <= '0;
            store_q   <= '0;
        end else begin
            rst_cnt_q <= rst_cnt_d;
            cycle_q   <= cycle_d;
            store_q   <= store_d;
        end
    end

    assign cycle_count_o = cycle_q;
    assign store_count_o = store_q;

endmodule

// File: doc/cpu_run_ctrl.md
Name:
cpu_run_ctrl

Overview:
Synthesizable run controller for the MIPS cores (single-cycle and later multi-cycle/pipelined).
- Sequences the CPU reset after a start request.
- Counts executed clock cycles and data-memory stores.
- Detects program completion by a halt instruction or a PC self-loop, and detects a runaway program by cycle timeout.
- Sits between the top-level harness and the CPU's rst input; watches inst_adr, inst and mem_write.

Parameters:
ADDR_W, 32, width of inst_adr
INST_W, 32, width of inst
CNT_W, 16, width of cycle_count and store_count
RST_CYCLES, 2, number of clock cycles cpu_rst is held high after start (>=1)
MAX_CYCLES, 312, RUN cycles allowed before timeout (>=1, < 2^CNT_W)
HALT_INST, 32'h0000000C, instruction word that terminates the run (MIPS syscall)
STALL_LIMIT, 4, consecutive cycles with an unchanged PC that count as halted (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle run request
inst_adr  in  ADDR_W  CPU program counter
inst  in  INST_W  instruction currently fetched
mem_write  in  1  CPU data-memory write strobe
cpu_rst  out  1  reset to the CPU, active-high
running  out  1  high while in RUN
done  out  1  sticky: run ended by halt
timeout  out  1  sticky: run ended by MAX_CYCLES
cycle_count  out  CNT_W  RUN cycles elapsed
store_count  out  CNT_W  mem_write cycles seen in RUN

Behaviour:
- Clocking and reset: one clock, clk; reset rst is asynchronous and active-high.
  - rst asserted at any time, including mid-RUN: state=IDLE immediately.
  - Reset values: cpu_rst=1, running=0, done=0, timeout=0, cycle_count=0, store_count=0, internal counters 0.
- States: IDLE, RESET, RUN, DONE, TIMEOUT.
- IDLE:
  - cpu_rst=1.
  - start=1 sampled -> RESET; cycle_count, store_count, done and timeout are cleared on that edge.
- RESET:
  - cpu_rst=1; rst_cnt counts RST_CYCLES edges, then -> RUN.
  - cpu_rst is therefore high for exactly RST_CYCLES cycles after the start edge.
  - start is ignored.
- RUN:
  - cpu_rst=0, running=1.
  - Each edge: cycle_count+1.
  - Each edge with mem_write=1: store_count+1, saturating at all-ones.
- Halt detection, evaluated each RUN cycle on the current inputs:
  - inst==HALT_INST -> DONE.
  - PC self-loop, see Optional Feature.
  - The cycle in which halt is seen is counted, so HALT_INST seen in the Nth RUN cycle gives cycle_count=N.
- Timeout: if the incremented count equals MAX_CYCLES and no halt is seen that cycle -> TIMEOUT.
- Halt and timeout in the same cycle: DONE wins (done=1, timeout=0).
- start during RUN is ignored.
- DONE / TIMEOUT:
  - cpu_rst=1 (freezes the CPU), running=0.
  - The matching flag is 1; both counters hold.
  - start -> RESET with counters and flags cleared, i.e. a restart.
- Outputs are registered from the state; cpu_rst, running, done and timeout are decoded from state flops only, with no combinational path from inputs.

Optional Feature:
STALL_DET_EN
- Defined:
  - prev_adr register loads inst_adr every RUN cycle.
  - stable_cnt increments when inst_adr==prev_adr and clears otherwise.
  - The comparison is disabled in the first RUN cycle.
  - stable_cnt reaching STALL_LIMIT -> DONE; this detects "j ." loops.
- Not defined: prev_adr and stable_cnt are absent; only HALT_INST or timeout end a run.

Test Plan:
1. Bench parameters: RST_CYCLES=2, MAX_CYCLES=20, STALL_LIMIT=3, STALL_DET_EN defined; PC +4 per cycle unless stated.
2. Start and halt: pulse start -> cpu_rst high exactly 2 cycles, then running=1. HALT_INST on 6th RUN cycle -> done=1, timeout=0, cycle_count=6, cpu_rst=1.
3. Timeout and stores: no halt -> timeout=1, done=0, cycle_count=20. 3 mem_write pulses during the run -> store_count=3.
4. PC self-loop: PC sticks at 0x10 for 3 repeat cycles -> done=1. Rebuilt without STALL_DET_EN, same stimulus -> timeout=1 at 20.
5. Simultaneous halt and timeout: HALT_INST exactly in RUN cycle 20 -> done=1, timeout=0, cycle_count=20.
6. Start handling and async reset:
   - start during RUN is ignored; the counts are unchanged.
   - start in DONE -> flags and counters are 0 and cpu_rst is high 2 cycles again.
   - rst asserted between clock edges mid-RUN -> all outputs return to reset values before the next edge.
